fp_align_addsub: RTL and testbench

FP_ALIGN_ADDSUB -- requirements
Module: fp_align_addsub

---
 rtl/fp_pkg.sv | 8 +
 rtl/fp_unpack.sv | 13 +
 rtl/fp_align_addsub.sv | 74 +++++++
 tb/tb_fp_align_addsub.sv | 132 +++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, limits and FSM state encoding for the FP align/add-sub block
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int ALIGN_LIMIT = 24;
  typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;
endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: split an IEEE-754 single into sign, exponent and hidden-bit mantissa
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]      word,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [MAN_W:0]   man
);
  assign sign = word[31];
  assign exp  = word[30:23];
  assign man  = {exp != '0, word[MAN_W-1:0]};
endmodule

// File: rtl/fp_align_addsub.sv
// fp_align_addsub: multi-cycle exponent alignment followed by mantissa add/subtract
module fp_align_addsub
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      res,
  output logic [EXP_W-1:0] exp_base,
  output logic             sign_res,
  output logic             out_special
);
  state_t state, state_n;
  logic sa, sb, sbe, a_x, spec_n, far_n, accept, sx, sy, special;
  logic [EXP_W-1:0] ea, eb, ex_n, ey_n, diff_n;
  logic [MAN_W:0] ma, mb, mx, my;
  logic [4:0] cnt;
  logic [24:0] sum;
  fp_unpack u_a (.word(a), .sign(sa), .exp(ea), .man(ma));
  fp_unpack u_b (.word(b), .sign(sb), .exp(eb), .man(mb));
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign accept    = in_valid && in_ready;
  assign sbe       = sb ^ op;
  assign a_x       = a[30:0] >= b[30:0];
  assign ex_n      = a_x ? ea : eb;
  assign ey_n      = a_x ? eb : ea;
  assign diff_n    = ex_n - ey_n;
  assign spec_n    = (ea == EXP_MAX) || (eb == EXP_MAX);
  assign far_n     = diff_n >= EXP_W'(ALIGN_LIMIT);
  assign sum       = (sx == sy) ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next-state: skip ALIGN when no shift is needed or the operand is special/out of range
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = !accept ? IDLE : (spec_n || far_n || diff_n == '0) ? ADD : ALIGN;
      ALIGN: state_n = (cnt == 5'd1) ? ADD : ALIGN;
      ADD:   state_n = DONE;
      DONE:  state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // datapath: capture ordered operands, shift Y one bit per ALIGN cycle, form result in ADD
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mx <= '0; my <= '0; sx <= 1'b0; sy <= 1'b0; cnt <= '0; special <= 1'b0;
      res <= '0; exp_base <= '0; sign_res <= 1'b0; out_special <= 1'b0;
    end else if (accept) begin
      mx       <= a_x ? ma : mb;
      my       <= (far_n && !spec_n) ? '0 : (a_x ? mb : ma);
      sx       <= a_x ? sa : sbe;
      sy       <= a_x ? sbe : sa;
      cnt      <= far_n ? '0 : diff_n[4:0];
      special  <= spec_n;
      exp_base <= spec_n ? EXP_MAX : ex_n;
    end else if (state == ALIGN) begin
      my  <= my >> 1;
      cnt <= cnt - 5'd1;
    end else if (state == ADD) begin
      res         <= special ? '0 : sum;
      sign_res    <= (sx != sy && sum == '0 && !special) ? 1'b0 : sx;
      out_special <= special;
    end
endmodule

// File: tb/tb_fp_align_addsub.sv
// tb_fp_align_addsub: directed table, corner sequences and randomized checks against a reference model
module tb_fp_align_addsub;
  logic clk = 0, rst_n = 0, in_valid = 0, op = 0, out_ready = 0;
  logic in_ready, out_valid, sign_res, out_special;
  logic [31:0] a = 0, b = 0;
  logic [24:0] res;
  logic [7:0] exp_base;
  int passed = 0, total = 0;

  fp_align_addsub dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .exp_base(exp_base), .sign_res(sign_res), .out_special(out_special));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic op;
    logic [24:0] r;
    logic [7:0] e;
    logic s, sp;
    int lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s got=%h expected=%h", name, act, exp);
  endtask

  function automatic void model(input logic [31:0] va, input logic [31:0] vb, input logic vop,
      output logic [24:0] r, output logic [7:0] e, output logic s, output logic sp, output int lat);
    int xa, xb, ex, ey, d, mx, my, sgx, sgy, mag;
    xa = va[30:23]; xb = vb[30:23];
    sp = (xa == 255) || (xb == 255);
    if (va[30:0] >= vb[30:0]) begin
      ex = xa; ey = xb; sgx = va[31]; sgy = vb[31] ^ vop;
      mx = (xa != 0 ? 8388608 : 0) + int'(va[22:0]); my = (xb != 0 ? 8388608 : 0) + int'(vb[22:0]);
    end else begin
      ex = xb; ey = xa; sgx = vb[31] ^ vop; sgy = va[31];
      mx = (xb != 0 ? 8388608 : 0) + int'(vb[22:0]); my = (xa != 0 ? 8388608 : 0) + int'(va[22:0]);
    end
    d = ex - ey;
    my = (d >= 24) ? 0 : my / (2 ** d);
    mag = (sgx == sgy) ? mx + my : mx - my;
    r = sp ? 25'd0 : 25'(mag);
    e = sp ? 8'hFF : 8'(ex);
    s = (!sp && sgx != sgy && mag == 0) ? 1'b0 : sgx[0];
    lat = (!sp && d > 0 && d < 24) ? d + 1 : 1;
  endfunction

  task automatic xact(input logic [31:0] ta, input logic [31:0] tbv, input logic top,
      output logic [24:0] r, output logic [7:0] e, output logic s, output logic sp, output int lat);
    @(negedge clk); a = ta; b = tbv; op = top; in_valid = 1;
    @(posedge clk); #1 in_valid = 0; lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    r = res; e = exp_base; s = sign_res; sp = out_special;
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
  endtask

  task automatic run_check(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
      input logic top, input logic [24:0] er, input logic [7:0] ee, input logic es, input logic esp, input int elat);
    logic [24:0] r; logic [7:0] e; logic s, sp; int lat;
    xact(ta, tbv, top, r, e, s, sp, lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_res"}, r, er);
    chk({tag, "_exp"}, e, ee);
    chk({tag, "_sign"}, s, es);
    chk({tag, "_special"}, sp, esp);
  endtask

  initial begin
    vec_t vecs[8];
    logic [24:0] r0, mr; logic [7:0] me; logic ms, msp; int mlat, seen;
    logic [31:0] ra, rb; logic rop;
    vecs[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 25'h1000000, 8'h7F, 1'b0, 1'b0, 1};
    vecs[1] = '{32'h3F800000, 32'h3F000000, 1'b0, 25'h0C00000, 8'h7F, 1'b0, 1'b0, 2};
    vecs[2] = '{32'h40000000, 32'h40400000, 1'b1, 25'h0400000, 8'h80, 1'b1, 1'b0, 1};
    vecs[3] = '{32'h3F800000, 32'h3F800000, 1'b1, 25'h0000000, 8'h7F, 1'b0, 1'b0, 1};
    vecs[4] = '{32'h4B800000, 32'h3F800000, 1'b0, 25'h0800000, 8'h97, 1'b0, 1'b0, 1};
    vecs[5] = '{32'h7F800000, 32'h3F800000, 1'b0, 25'h0000000, 8'hFF, 1'b0, 1'b1, 1};
    vecs[6] = '{32'h44800000, 32'h3F800000, 1'b0, 25'h0802000, 8'h89, 1'b0, 1'b0, 11};
    vecs[7] = '{32'hC0000000, 32'h3F800000, 1'b0, 25'h0400000, 8'h80, 1'b1, 1'b0, 2};
    #12;
    chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0); chk("rst_exp", exp_base, 0);
    chk("rst_sign", sign_res, 0); chk("rst_special", out_special, 0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 8; i++)
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                vecs[i].r, vecs[i].e, vecs[i].s, vecs[i].sp, vecs[i].lat);
    // stall with out_ready low; new operands offered meanwhile must be ignored
    @(negedge clk); a = 32'h3F800000; b = 32'h3F000000; op = 0; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (2) @(posedge clk);
    #1 chk("stall_valid", out_valid, 1);
    r0 = res;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); a = $urandom; b = $urandom; in_valid = 1;
      @(posedge clk); #1;
      chk("stall_hold_valid", out_valid, 1); chk("stall_in_ready", in_ready, 0);
      chk("stall_res", res, r0); chk("stall_exp", exp_base, 8'h7F);
    end
    @(negedge clk); in_valid = 0; out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    chk("stall_release_valid", out_valid, 0); chk("stall_release_ready", in_ready, 1);
    // reset in the middle of a long alignment
    @(negedge clk); a = 32'h44800000; b = 32'h3F800000; op = 0; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 0; #1;
    chk("midrst_valid", out_valid, 0); chk("midrst_ready", in_ready, 1);
    chk("midrst_res", res, 0); chk("midrst_exp", exp_base, 0);
    @(negedge clk); rst_n = 1;
    seen = 0;
    repeat (15) begin @(posedge clk); #1 if (out_valid) seen++; end
    chk("midrst_no_ghost", seen, 0);
    run_check("post_rst", 32'h3F800000, 32'h3F000000, 1'b0, 25'h0C00000, 8'h7F, 1'b0, 1'b0, 2);
    // randomized operands, half with nearby exponents to exercise alignment
    for (int i = 0; i < 200; i++) begin
      ra = $urandom; rop = 1'($urandom);
      rb = $urandom;
      if (i % 2 == 0) rb[30:23] = ra[30:23] - 8'($urandom_range(0, 30));
      if (i % 17 == 0) rb[30:23] = 8'hFF;
      model(ra, rb, rop, mr, me, ms, msp, mlat);
      run_check($sformatf("rnd%0d", i), ra, rb, rop, mr, me, ms, msp, mlat);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
